// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//
// Shared definitions for the multi-approach traffic phase controller.
//   - PH_* : 3-bit phase encodings, also driven on the debug 'phase' port
//   - state_e : controller state type, encoded with the PH_* values
//   - idx_width() : width of an approach index for a given approach count
// ---------------------------------------------------------------------------
package traffic_pkg;

  // Phase encodings. The debug port shows these values directly, so they are
  // kept stable and independent of the enum declaration order.
  localparam logic [2:0] PH_GREEN  = 3'd0;
  localparam logic [2:0] PH_YELLOW = 3'd1;
  localparam logic [2:0] PH_ALLRED = 3'd2;
  localparam logic [2:0] PH_WALK   = 3'd3;
  localparam logic [2:0] PH_FLASH  = 3'd4;

  typedef enum logic [2:0] {
    ST_GREEN  = PH_GREEN,
    ST_YELLOW = PH_YELLOW,
    ST_ALLRED = PH_ALLRED,
    ST_WALK   = PH_WALK,
    ST_FLASH  = PH_FLASH
  } state_e;

  // Bits needed to index n approaches. A single bit is the floor, so the
  // index port never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_next_way.sv
// ---------------------------------------------------------------------------
// rr_next_way
//
// Combinational round-robin approach selector.
//   pend      in  NUM_WAYS  pending demand per approach
//   cur_way   in  IDX_W     approach currently or most recently served
//   next_way  out IDX_W     first pending approach after cur_way (wrapping,
//                           cur_way itself checked last); cur_way+1 when
//                           nothing is pending
//   any_pend  out 1         at least one approach has demand
// ---------------------------------------------------------------------------
module rr_next_way
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  localparam int IDX_W = idx_width(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] pend,
  input  logic [IDX_W-1:0]    cur_way,
  output logic [IDX_W-1:0]    next_way,
  output logic                any_pend
);

  // Walk the approaches starting just after the one being served and keep
  // the first one with demand. Offsets run 1..NUM_WAYS so the current
  // approach is the final candidate, which lets a request that arrived for
  // it after its green ended still be picked up once everyone else is done.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    next_way = IDX_W'((int'(cur_way) + 1) % NUM_WAYS);
    for (int k = 1; k <= NUM_WAYS; k++) begin
      cand = IDX_W'((int'(cur_way) + k) % NUM_WAYS);
      if (!found && pend[cand]) begin
        next_way = cand;
        found    = 1'b1;
      end
    end
  end

  assign any_pend = |pend;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Multi-approach traffic signal controller. Approaches are served
// round-robin on demand: GREEN -> YELLOW -> ALLRED -> (WALK) -> GREEN of the
// next approach. A maintenance request forces a flashing-yellow mode that
// exits through a full all-red clearance.
//
// Ports:
//   clk       in  1         system clock
//   rst       in  1         asynchronous reset, active-low
//   veh_req   in  NUM_WAYS  per-approach vehicle demand (level or pulse)
//   ped_req   in  1         pedestrian push-button (pulse)
//   flash_en  in  1         maintenance flash request (level)
//   green     out NUM_WAYS  per-approach green lamp
//   yellow    out NUM_WAYS  per-approach yellow lamp
//   red       out NUM_WAYS  per-approach red lamp
//   walk      out 1         pedestrian walk lamp
//   cur_way   out IDX_W     approach currently or most recently served
//   phase     out 3         current state encoding (debug)
//
// Every output comes straight from a flop; the lamp flops are loaded with
// the lamp pattern of the state being entered, so lamps change on the same
// edge as the state.
// ---------------------------------------------------------------------------
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS   = 2,
  parameter int CNT_W      = 16,
  parameter int GREEN_MIN  = 30,
  parameter int YELLOW_CYC = 5,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 20,
  parameter int FLASH_CYC  = 4,
  localparam int IDX_W = idx_width(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAYS-1:0] veh_req,
  input  logic                ped_req,
  input  logic                flash_en,
  output logic [NUM_WAYS-1:0] green,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] red,
  output logic                walk,
  output logic [IDX_W-1:0]    cur_way,
  output logic [2:0]          phase
);

  // Last timer value of each timed phase: a phase of D cycles exits on the
  // edge where the timer reads D-1.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);

  localparam logic [NUM_WAYS-1:0] RST_GREEN = NUM_WAYS'(1);

  state_e              state_q,    state_d;
  logic [IDX_W-1:0]    cur_q,      cur_d;
  logic [CNT_W-1:0]    timer_q,    timer_d;
  logic [NUM_WAYS-1:0] pend_q,     pend_d;
  logic                ped_pend_q, ped_pend_d;
  logic                toggle_q,   toggle_d;
  logic [NUM_WAYS-1:0] green_q,    green_d;
  logic [NUM_WAYS-1:0] yellow_q,   yellow_d;
  logic [NUM_WAYS-1:0] red_q,      red_d;
  logic                walk_q,     walk_d;

  logic [NUM_WAYS-1:0] cur_oh_q;
  logic [NUM_WAYS-1:0] cur_oh_d;
  logic [NUM_WAYS-1:0] pend_view;
  logic [IDX_W-1:0]    next_way;
  logic                any_pend;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [IDX_W-1:0] w);
    logic [NUM_WAYS-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    return oh;
  endfunction

  assign cur_oh_q = way_onehot(cur_q);
  assign cur_oh_d = way_onehot(cur_d);

  // While an approach is green its own latch must not count as demand to
  // leave green. Outside GREEN the selector sees every pending approach.
  assign pend_view = (state_q == ST_GREEN) ? (pend_q & ~cur_oh_q) : pend_q;

  rr_next_way #(
    .NUM_WAYS (NUM_WAYS)
  ) u_rr_next_way (
    .pend     (pend_view),
    .cur_way  (cur_q),
    .next_way (next_way),
    .any_pend (any_pend)
  );

  // Next-state and served-approach selection. Maintenance flash overrides
  // everything; otherwise each timed phase exits on its last timer value.
  // GREEN only leaves when someone else is waiting, so an idle junction
  // rests on the current approach.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    if (flash_en) begin
      state_d = ST_FLASH;
    end else begin
      case (state_q)
        ST_GREEN: begin
          if (timer_q >= GREEN_LAST && (any_pend || ped_pend_q)) begin
            state_d = ST_YELLOW;
          end
        end
        ST_YELLOW: begin
          if (timer_q >= YELLOW_LAST) begin
            state_d = ST_ALLRED;
          end
        end
        ST_ALLRED: begin
          if (timer_q >= ALLRED_LAST) begin
            if (ped_pend_q) begin
              state_d = ST_WALK;
            end else begin
              state_d = ST_GREEN;
              cur_d   = next_way;
            end
          end
        end
        ST_WALK: begin
          if (timer_q >= WALK_LAST) begin
            state_d = ST_GREEN;
            cur_d   = next_way;
          end
        end
        ST_FLASH: begin
          state_d = ST_ALLRED;
        end
        default: begin
          state_d = ST_ALLRED;
        end
      endcase
    end
  end

  // Phase timer and flash toggle. Any state change restarts the timer and
  // re-arms the toggle so flash always opens with the lamps on. In FLASH the
  // timer counts one half-period and wraps; in GREEN it saturates so a long
  // rest cannot wrap back below the minimum-green threshold.
  always_comb begin
    timer_d  = timer_q;
    toggle_d = toggle_q;
    if (state_d != state_q) begin
      timer_d  = '0;
      toggle_d = 1'b1;
    end else if (state_q == ST_FLASH) begin
      if (timer_q >= FLASH_LAST) begin
        timer_d  = '0;
        toggle_d = ~toggle_q;
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end else if (timer_q != '1) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  // Demand latches. Requests accumulate, except that a request for the
  // approach currently showing green is absorbed. On entry to an approach's
  // green (or to WALK) the matching latch is cleared, but a request landing
  // on that same edge is kept.
  always_comb begin
    pend_d = pend_q | veh_req;
    if (state_q == ST_GREEN) begin
      pend_d = pend_d & ~cur_oh_q;
    end
    if (state_d == ST_GREEN && state_q != ST_GREEN) begin
      pend_d = (pend_d & ~cur_oh_d) | (veh_req & cur_oh_d);
    end
    ped_pend_d = ped_pend_q | ped_req;
    if (state_d == ST_WALK && state_q != ST_WALK) begin
      ped_pend_d = ped_req;
    end
  end

  // Lamp pattern for the state being entered. Everything not explicitly lit
  // is red, except in FLASH where every lamp but the shared yellow is dark.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    walk_d   = 1'b0;
    case (state_d)
      ST_GREEN: begin
        green_d = cur_oh_d;
        red_d   = ~cur_oh_d;
      end
      ST_YELLOW: begin
        yellow_d = cur_oh_d;
        red_d    = ~cur_oh_d;
      end
      ST_ALLRED: begin
        red_d = '1;
      end
      ST_WALK: begin
        walk_d = 1'b1;
      end
      ST_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_WAYS{toggle_d}};
      end
      default: begin
        red_d = '1;
      end
    endcase
  end

  // State, timer, latch and lamp registers. Reset lands on approach 0 green
  // with all demand forgotten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_GREEN;
      cur_q      <= '0;
      timer_q    <= '0;
      pend_q     <= '0;
      ped_pend_q <= 1'b0;
      toggle_q   <= 1'b1;
      green_q    <= RST_GREEN;
      yellow_q   <= '0;
      red_q      <= ~RST_GREEN;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      ped_pend_q <= ped_pend_d;
      toggle_q   <= toggle_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
      walk_q     <= walk_d;
    end
  end

  assign green   = green_q;
  assign yellow  = yellow_q;
  assign red     = red_q;
  assign walk    = walk_q;
  assign cur_way = cur_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//
// Directed scenarios followed by a randomized run, all checked each cycle
// against a phase/age reference model of the controller.
// ---------------------------------------------------------------------------
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int NW   = 3;
  localparam int GMIN = 8;
  localparam int YCYC = 3;
  localparam int ACYC = 2;
  localparam int WCYC = 6;
  localparam int FCYC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] veh_req = '0;
  logic          ped_req = 1'b0;
  logic          flash_en = 1'b0;
  logic [NW-1:0] green;
  logic [NW-1:0] yellow;
  logic [NW-1:0] red;
  logic          walk;
  logic [1:0]    cur_way;
  logic [2:0]    phase;

  int checks = 0;
  int failures = 0;

  typedef enum int {M_GREEN, M_YELLOW, M_ALLRED, M_WALK, M_FLASH} mphase_t;

  mphase_t   m_phase;
  int        m_way;
  int        m_age;
  bit [NW-1:0] m_pend;
  bit        m_ped;

  traffic_phase_ctrl #(
    .NUM_WAYS   (NW),
    .CNT_W      (16),
    .GREEN_MIN  (GMIN),
    .YELLOW_CYC (YCYC),
    .ALLRED_CYC (ACYC),
    .WALK_CYC   (WCYC),
    .FLASH_CYC  (FCYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .veh_req  (veh_req),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .green    (green),
    .yellow   (yellow),
    .red      (red),
    .walk     (walk),
    .cur_way  (cur_way),
    .phase    (phase)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_phase = M_GREEN;
    m_way   = 0;
    m_age   = 0;
    m_pend  = '0;
    m_ped   = 1'b0;
  endtask

  // Round robin: first waiting approach after the served one, wrapping.
  function automatic int pickNextWay();
    for (int k = 1; k <= NW; k++) begin
      int j;
      j = (m_way + k) % NW;
      if (m_pend[j]) return j;
    end
    return (m_way + 1) % NW;
  endfunction

  // One clock of the reference: m_age counts cycles already spent in the
  // phase, so this edge completes cycle m_age+1.
  task automatic modelStep(input logic [NW-1:0] vr, input logic pr, input logic fe);
    mphase_t     nxt;
    int          nway;
    int          served;
    bit          others;
    bit [NW-1:0] np;
    bit          nped;
    served = m_age + 1;
    nxt    = m_phase;
    nway   = m_way;
    others = 1'b0;
    for (int j = 0; j < NW; j++) begin
      if (j != m_way && m_pend[j]) others = 1'b1;
    end
    if (fe) begin
      nxt = M_FLASH;
    end else begin
      case (m_phase)
        M_GREEN:  if (served >= GMIN && (others || m_ped)) nxt = M_YELLOW;
        M_YELLOW: if (served >= YCYC) nxt = M_ALLRED;
        M_ALLRED: begin
          if (served >= ACYC) begin
            if (m_ped) nxt = M_WALK;
            else begin
              nxt  = M_GREEN;
              nway = pickNextWay();
            end
          end
        end
        M_WALK: begin
          if (served >= WCYC) begin
            nxt  = M_GREEN;
            nway = pickNextWay();
          end
        end
        default: nxt = M_ALLRED;
      endcase
    end
    np = m_pend | vr;
    if (m_phase == M_GREEN) np[m_way] = 1'b0;
    if (nxt == M_GREEN && m_phase != M_GREEN) np[nway] = vr[nway];
    nped = m_ped | pr;
    if (nxt == M_WALK && m_phase != M_WALK) nped = pr;
    m_age   = (nxt == m_phase) ? served : 0;
    m_phase = nxt;
    m_way   = nway;
    m_pend  = np;
    m_ped   = nped;
  endtask

  task automatic checkOutput(input string tag);
    logic [NW-1:0] eg;
    logic [NW-1:0] ey;
    logic [NW-1:0] er;
    logic          ew;
    logic [2:0]    eph;
    eg  = '0;
    ey  = '0;
    er  = '1;
    ew  = 1'b0;
    eph = PH_ALLRED;
    case (m_phase)
      M_GREEN: begin
        eg[m_way] = 1'b1;
        er[m_way] = 1'b0;
        eph = PH_GREEN;
      end
      M_YELLOW: begin
        ey[m_way] = 1'b1;
        er[m_way] = 1'b0;
        eph = PH_YELLOW;
      end
      M_ALLRED: eph = PH_ALLRED;
      M_WALK: begin
        ew  = 1'b1;
        eph = PH_WALK;
      end
      default: begin
        er  = '0;
        ey  = (((m_age / FCYC) % 2) == 0) ? '1 : '0;
        eph = PH_FLASH;
      end
    endcase
    checkValue({tag, "_green"},  8'(green),   8'(eg));
    checkValue({tag, "_yellow"}, 8'(yellow),  8'(ey));
    checkValue({tag, "_red"},    8'(red),     8'(er));
    checkValue({tag, "_walk"},   8'(walk),    8'(ew));
    checkValue({tag, "_cur"},    8'(cur_way), 8'(m_way));
    checkValue({tag, "_phase"},  8'(phase),   8'(eph));
  endtask

  // Drive inputs away from the edge, clock once, then compare with the model.
  task automatic applyStimulus(input logic [NW-1:0] vr, input logic pr, input logic fe);
    veh_req  = vr;
    ped_req  = pr;
    flash_en = fe;
    @(posedge clk);
    modelStep(vr, pr, fe);
    #1;
    checkOutput("cyc");
  endtask

  // Asynchronous reset: outputs must change without a clock edge.
  task automatic doReset();
    veh_req  = '0;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    rst      = 1'b0;
    modelReset();
    #1;
    checkOutput("rst");
    checkValue("rst_green", 8'(green), 8'(3'b001));
    checkValue("rst_red",   8'(red),   8'(3'b110));
    checkValue("rst_walk",  8'(walk),  8'(1'b0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [NW-1:0] vr;
    logic          pr;
    logic          fe;
    int            flash_left;
    int            last;
    bit            got;
    int            served_q[$];

    $display("[TB] start");
    #2;
    doReset();

    $display("[TB] idle rest on approach 0");
    for (int i = 0; i < 100; i++) applyStimulus('0, 1'b0, 1'b0);
    checkValue("idle_green", 8'(green), 8'(3'b001));
    checkValue("idle_red",   8'(red),   8'(3'b110));
    checkValue("idle_walk",  8'(walk),  8'(1'b0));

    $display("[TB] single request for approach 2");
    doReset();
    for (int i = 1; i <= 13; i++) begin
      applyStimulus((i == 3) ? 3'b100 : 3'b000, 1'b0, 1'b0);
      if (i == 7)  checkValue("t3_green_held", 8'(green),  8'(3'b001));
      if (i == 8)  checkValue("t3_yellow_in",  8'(yellow), 8'(3'b001));
      if (i == 10) checkValue("t3_yellow_end", 8'(yellow), 8'(3'b001));
      if (i == 11) checkValue("t3_allred",     8'(red),    8'(3'b111));
      if (i == 12) checkValue("t3_allred2",    8'(red),    8'(3'b111));
      if (i == 13) begin
        checkValue("t3_green2", 8'(green),   8'(3'b100));
        checkValue("t3_cur2",   8'(cur_way), 8'(2'd2));
      end
    end

    $display("[TB] pedestrian plus approach 1");
    doReset();
    for (int i = 1; i <= 19; i++) begin
      applyStimulus((i == 2) ? 3'b010 : 3'b000, i == 2, 1'b0);
      if (i == 8)  checkValue("t4_yellow", 8'(yellow), 8'(3'b001));
      if (i == 11) checkValue("t4_allred", 8'(red),    8'(3'b111));
      if (i == 13) begin
        checkValue("t4_walk_red", 8'(red),  8'(3'b111));
        checkValue("t4_walk_on",  8'(walk), 8'(1'b1));
      end
      if (i == 18) checkValue("t4_walk_end", 8'(walk), 8'(1'b1));
      if (i == 19) begin
        checkValue("t4_green1",  8'(green), 8'(3'b010));
        checkValue("t4_walk_off", 8'(walk), 8'(1'b0));
      end
    end

    $display("[TB] wrap order 2 then 0");
    last = 1;
    for (int j = 1; j <= 40; j++) begin
      applyStimulus((j == 1) ? 3'b101 : 3'b000, 1'b0, 1'b0);
      if (green !== 3'b000 && int'(cur_way) != last) begin
        served_q.push_back(int'(cur_way));
        last = int'(cur_way);
      end
    end
    checkValue("t5_count", 8'(served_q.size()), 8'd2);
    checkValue("t5_first",  (served_q.size() >= 1) ? 8'(served_q[0]) : 8'hFF, 8'd2);
    checkValue("t5_second", (served_q.size() >= 2) ? 8'(served_q[1]) : 8'hFF, 8'd0);

    $display("[TB] flash from yellow");
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      applyStimulus((k == 0) ? 3'b010 : 3'b000, 1'b0, 1'b0);
      if (yellow !== 3'b000) got = 1'b1;
    end
    checkValue("t6_reach_yellow", 8'(yellow), 8'(3'b001));
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k == 2) ? 3'b100 : 3'b000, 1'b0, 1'b1);
      if (k == 0) begin
        checkValue("t6_flash_green", 8'(green),  8'(3'b000));
        checkValue("t6_flash_red",   8'(red),    8'(3'b000));
        checkValue("t6_flash_on",    8'(yellow), 8'(3'b111));
      end
      if (k == 3) checkValue("t6_flash_on_end", 8'(yellow), 8'(3'b111));
      if (k == 4) checkValue("t6_flash_off",    8'(yellow), 8'(3'b000));
      if (k == 8) checkValue("t6_flash_on2",    8'(yellow), 8'(3'b111));
    end
    for (int k = 1; k <= 3; k++) begin
      applyStimulus('0, 1'b0, 1'b0);
      if (k <= 2) checkValue("t6_exit_allred", 8'(red), 8'(3'b111));
      if (k == 3) begin
        checkValue("t6_exit_green", 8'(green),   8'(3'b010));
        checkValue("t6_exit_cur",   8'(cur_way), 8'(2'd1));
      end
    end

    $display("[TB] reset during walk");
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      applyStimulus('0, k == 0, 1'b0);
      if (walk === 1'b1) got = 1'b1;
    end
    checkValue("t7_reach_walk", 8'(walk), 8'(1'b1));
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    doReset();
    checkValue("t7_cur", 8'(cur_way), 8'(2'd0));
    for (int k = 0; k < 20; k++) applyStimulus('0, 1'b0, 1'b0);
    checkValue("t7_no_ped", 8'(green), 8'(3'b001));
    checkValue("t7_walk",   8'(walk),  8'(1'b0));

    $display("[TB] randomized run");
    flash_left = 0;
    for (int i = 0; i < 400; i++) begin
      vr = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pr = ($urandom_range(0, 29) == 0);
      if (flash_left == 0 && $urandom_range(0, 99) == 0) flash_left = int'($urandom_range(3, 12));
      fe = (flash_left > 0);
      if (flash_left > 0) flash_left--;
      applyStimulus(vr, pr, fe);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
